fetch_prefetch_unit: RTL and testbench
======================================

// Module: fetch_prefetch_unit
// PURPOSE
//  Parametrised instruction fetch unit. It holds the fetch PC and issues pipelined requests
//  to instruction memory over a req/gnt/rvalid bus, with up to DEPTH requests in flight.
//  Returned words go into a DEPTH-entry prefetch queue, which feeds decode through a
//  valid/ready handshake. Jump, branch and register redirects flush the queue and discard
//  stale in-flight responses.
// PARAMETERS
//  AW        32  fetch PC width (byte address)
//  IM_AW     12  instruction-memory address width; im_addr = fetch_pc[IM_AW-1:0]
//  DEPTH     4   prefetch queue entries = max in-flight + queued words (power of 2, >=2)
//  RESET_PC  0   fetch PC value after reset
// PORTS
//  clk              in   1      system clock, rising edge
//  reset            in   1      asynchronous, active-low reset
//  redirect_valid   in   1      redirect strobe, one cycle
//  redirect_sel     in   2      00 reg target, 01 jump, 10 branch, 11 reserved (treated as 00)
//  redirect_pc      in   AW     PC of the redirecting instruction
//  redirect_ir      in   32     IR of the redirecting instruction
//  redirect_target  in   AW     absolute target, used when sel=00
//  im_req           out  1      fetch request
//  im_addr          out  IM_AW  fetch byte address
//  im_gnt           in   1      request accepted this cycle
//  im_rvalid        in   1      read data valid; responses return in order, latency >=1
//  im_rdata         in   32     read data
//  if_valid         out  1      queue head valid
//  if_ready         in   1      decode accepts the head
//  if_ir            out  32     head instruction word
//  if_pc            out  AW     head instruction PC
//  if_se16          out  32     {{16{if_ir[15]}}, if_ir[15:0]}
// BEHAVIOUR
//  Reset (reset=0)
//   - fetch_pc=RESET_PC, resp_pc=RESET_PC, queue empty, out_cnt=0, drop_cnt=0.
//   - im_req=0 and if_valid=0 while reset=0.
//  Request issue
//   - im_req = !redirect_valid && (count + out_cnt < DEPTH).
//   - On im_req&&im_gnt: fetch_pc += 4 (wraps modulo 2^AW) and out_cnt++.
//   - im_addr is stable while im_req=1 and gnt=0.
//  Response
//   - On im_rvalid: out_cnt--.
//   - If drop_cnt>0: discard the word and drop_cnt--.
//   - Otherwise push {resp_pc, im_rdata} and resp_pc += 4.
//   - The credit rule guarantees no push when full. A push while full is an assertion failure.
//  Decode output
//   - Head is combinational from the queue.
//   - On if_valid&&if_ready: pop.
//   - Push and pop in the same cycle leave count unchanged.
//  Redirect (priority over pop, push and issue)
//   - seq = redirect_pc + 4.
//   - Targets: 01 {seq[AW-1:28], ir[25:0], 2'b00}; 10 seq + {se16(ir)[AW-3:0], 2'b00};
//     00/11 redirect_target.
//   - Next cycle: fetch_pc = resp_pc = target; queue emptied; if_valid=0.
//   - drop_cnt = out_cnt after this cycle's rvalid decrement.
//   - An rvalid arriving in the redirect cycle is discarded.
//   - A pop in the redirect cycle is ignored.
//   - Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
//  Latency
//   - Redirect to first im_req: 1 cycle.
//   - Response to if_valid: 1 cycle (registered queue write).
// STRUCTURE
//  - Package fetch_pkg: REDIR_REG/REDIR_JUMP/REDIR_BRANCH encodings, INSTR_W=32,
//    function sext16().
//  - Sub-module fetch_queue: sync FIFO, params WIDTH=AW+32 and DEPTH, with push, pop, flush,
//    count, empty, full. One clock, same reset.
//  - Top: fetch_pc, resp_pc, out_cnt and drop_cnt registers, target mux, credit logic.
// TESTING
//  1 Reset, then gnt=1 with latency-1 memory, if_ready=1: im_addr runs 0,4,8,...
//    if_pc=0,4,8 on consecutive cycles. if_se16 for ir=0x0000_8004 is 0xFFFF_8004.
//  2 if_ready=0, gnt=1: exactly DEPTH=4 requests issue, then im_req=0.
//    Raising if_ready for 1 cycle re-enables exactly one request.
//  3 Jump: redirect_pc=0x0000_0100, ir=0x0800_0040 -> if_pc of the next valid word =
//    0x0000_0100. Both in-flight responses are dropped.
//  4 Branch: redirect_pc=0x20, ir[15:0]=0xFFFE -> target 0x1C. Branch, ir[15:0]=0x0003 -> 0x30.
//  5 Redirect in the same cycle as rvalid and if_ready: word discarded, no pop.
//    The next queue entry carries the target PC.
//  6 Reset asserted mid-burst with 3 requests in flight: outputs clear immediately.
//    After release, fetch restarts at RESET_PC and no stale word reaches if_ir.

Source files
------------

// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared encodings and helpers for the instruction fetch/prefetch unit.
package fetch_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    REDIR_REG    = 2'b00,
    REDIR_JUMP   = 2'b01,
    REDIR_BRANCH = 2'b10,
    REDIR_RSVD   = 2'b11
  } redir_sel_e;

  // Sign-extend a 16-bit immediate to a full instruction-width word.
  function automatic logic [INSTR_W-1:0] sext16(input logic [15:0] imm);
    return {{(INSTR_W-16){imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/fetch_prefetch_unit_queue.sv
// Prefetch queue: synchronous FIFO holding {pc, instruction} pairs for decode.
// The head entry is presented combinationally; flush empties it in one cycle.
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && !empty;
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign rdata   = mem[rd_ptr];

  // Entry storage; contents are only meaningful where count marks them valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; a flush discards every entry at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch unit: issues pipelined fetches over a req/gnt/rvalid bus,
// buffers returned words in a prefetch queue and handles control-flow redirects.
// Credits: queued words plus outstanding requests never exceed DEPTH, so every
// response has a free queue slot waiting for it.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int            AW       = 32,
  parameter int            IM_AW    = 12,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [1:0]         redirect_sel,
  input  logic [AW-1:0]      redirect_pc,
  input  logic [INSTR_W-1:0] redirect_ir,
  input  logic [AW-1:0]      redirect_target,
  output logic               im_req,
  output logic [IM_AW-1:0]   im_addr,
  input  logic               im_gnt,
  input  logic               im_rvalid,
  input  logic [INSTR_W-1:0] im_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_ir,
  output logic [AW-1:0]      if_pc,
  output logic [INSTR_W-1:0] if_se16
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int QW = AW + INSTR_W;

  logic [AW-1:0]      fetch_pc;
  logic [AW-1:0]      resp_pc;
  logic [AW-1:0]      seq_pc;
  logic [AW-1:0]      redirect_tgt;
  logic [INSTR_W-1:0] branch_off;
  logic [CW-1:0]      out_cnt;
  logic [CW-1:0]      drop_cnt;
  logic [CW-1:0]      q_count;
  logic [CW:0]        credit_used;
  logic               issue;
  logic               q_push;
  logic               q_pop;
  logic               q_empty;
  logic               q_full;
  logic [QW-1:0]      q_wdata;
  logic [QW-1:0]      q_rdata;
  logic [5:0]         unused_ir_bits;

  // Opcode bits of the redirecting instruction play no part in target formation.
  assign unused_ir_bits = redirect_ir[31:26];

  // Redirect target: jump splices the 26-bit index into the sequential PC's
  // region, branch adds the word-scaled signed offset, anything else is absolute.
  always_comb begin
    seq_pc       = redirect_pc + AW'(4);
    branch_off   = sext16(redirect_ir[15:0]) << 2;
    redirect_tgt = redirect_target;
    case (redir_sel_e'(redirect_sel))
      REDIR_JUMP:   redirect_tgt = {seq_pc[AW-1:28], redirect_ir[25:0], 2'b00};
      REDIR_BRANCH: redirect_tgt = seq_pc + AW'(branch_off);
      default:      redirect_tgt = redirect_target;
    endcase
  end

  assign credit_used = {1'b0, q_count} + {1'b0, out_cnt};
  assign im_req      = reset && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
  assign issue       = im_req && im_gnt;
  assign im_addr     = fetch_pc[IM_AW-1:0];

  assign q_push  = im_rvalid && !redirect_valid && (drop_cnt == '0);
  assign q_pop   = if_valid && if_ready && !redirect_valid;
  assign q_wdata = {resp_pc, im_rdata};

  assign if_valid = !q_empty;
  assign if_pc    = q_rdata[QW-1:INSTR_W];
  assign if_ir    = q_rdata[INSTR_W-1:0];
  assign if_se16  = sext16(if_ir[15:0]);

  // PC and in-flight bookkeeping; a redirect marks every response still owed
  // after this cycle as stale so it is dropped on arrival.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      out_cnt  <= '0;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_tgt;
      resp_pc  <= redirect_tgt;
      out_cnt  <= out_cnt - CW'(im_rvalid);
      drop_cnt <= out_cnt - CW'(im_rvalid);
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + AW'(4);
      end
      out_cnt <= out_cnt + CW'(issue) - CW'(im_rvalid);
      if (im_rvalid) begin
        if (drop_cnt != '0) begin
          drop_cnt <= drop_cnt - CW'(1);
        end else begin
          resp_pc <= resp_pc + AW'(4);
        end
      end
    end
  end

  fetch_queue #(
    .WIDTH (QW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (q_push),
    .pop   (q_pop),
    .flush (redirect_valid),
    .wdata (q_wdata),
    .rdata (q_rdata),
    .count (q_count),
    .empty (q_empty),
    .full  (q_full)
  );

  // A response landing on a full queue means the credit accounting is broken.
  assert property (@(posedge clk) disable iff (!reset) !(q_push && q_full));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with an in-order instruction memory model.
module tb_fetch_prefetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [1:0]  redirect_sel;
  logic [31:0] redirect_pc;
  logic [31:0] redirect_ir;
  logic [31:0] redirect_target;
  logic        im_req;
  logic [11:0] im_addr;
  logic        im_gnt;
  logic        im_rvalid = 1'b0;
  logic [31:0] im_rdata = 32'h0;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_ir;
  logic [31:0] if_pc;
  logic [31:0] if_se16;

  logic        mem_go;
  logic [11:0] pend[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          grants;

  fetch_prefetch_unit #(
    .AW       (32),
    .IM_AW    (12),
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_sel    (redirect_sel),
    .redirect_pc     (redirect_pc),
    .redirect_ir     (redirect_ir),
    .redirect_target (redirect_target),
    .im_req          (im_req),
    .im_addr         (im_addr),
    .im_gnt          (im_gnt),
    .im_rvalid       (im_rvalid),
    .im_rdata        (im_rdata),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_ir           (if_ir),
    .if_pc           (if_pc),
    .if_se16         (if_se16)
  );

  always #5 clk = ~clk;

  // Memory contents: bit 15 set when address bit 3 is clear, so sign extension varies.
  function automatic logic [31:0] word(input logic [11:0] a);
    return {16'h0000, (a[3] ? 4'h0 : 4'h8), a};
  endfunction

  // In-order memory, one-cycle latency; mem_go=0 holds responses back.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend.delete();
      im_rvalid = 1'b0;
      im_rdata  = 32'h0;
    end else begin
      if (im_rvalid) void'(pend.pop_front());
      if (im_req && im_gnt) pend.push_back(im_addr);
      #1;
      im_rvalid = mem_go && (pend.size() != 0);
      im_rdata  = (pend.size() != 0) ? word(pend[0]) : 32'h0;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_req", 64'(im_req), 64'd0);
    checkOutput("rst_valid", 64'(if_valid), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic waitValid(input string tag, input logic [31:0] pc);
    int n;
    n = 0;
    while (!if_valid && n < 12) begin
      step();
      n++;
    end
    checkOutput({tag, "_valid"}, 64'(if_valid), 64'd1);
    checkOutput({tag, "_pc"}, 64'(if_pc), 64'(pc));
    checkOutput({tag, "_ir"}, 64'(if_ir), 64'(word(pc[11:0])));
  endtask

  task automatic applyStimulus(input string tag, input logic [1:0] sel, input logic [31:0] pc,
                               input logic [31:0] ir, input logic [31:0] tgt,
                               input logic [31:0] exp_target);
    redirect_valid  = 1'b1;
    redirect_sel    = sel;
    redirect_pc     = pc;
    redirect_ir     = ir;
    redirect_target = tgt;
    #1;
    checkOutput({tag, "_req_blocked"}, 64'(im_req), 64'd0);
    step();
    redirect_valid = 1'b0;
    im_gnt = 1'b1;
    mem_go = 1'b1;
    #1;
    checkOutput({tag, "_flushed"}, 64'(if_valid), 64'd0);
    checkOutput({tag, "_req"}, 64'(im_req), 64'd1);
    checkOutput({tag, "_addr"}, 64'(im_addr), 64'(exp_target[11:0]));
    waitValid(tag, exp_target);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: bench did not reach its end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    redirect_valid = 1'b0;
    redirect_sel = 2'b00;
    redirect_pc = 32'h0;
    redirect_ir = 32'h0;
    redirect_target = 32'h0;
    im_gnt = 1'b1;
    if_ready = 1'b1;
    mem_go = 1'b1;

    // Streaming fetch from reset
    doReset();
    for (int i = 0; i < 6; i++) begin
      checkOutput("t1_req", 64'(im_req), 64'd1);
      checkOutput("t1_addr", 64'(im_addr), 64'(4 * i));
      if (i < 2) begin
        checkOutput("t1_valid_lat", 64'(if_valid), 64'd0);
      end else begin
        checkOutput("t1_valid", 64'(if_valid), 64'd1);
        checkOutput("t1_pc", 64'(if_pc), 64'(4 * (i - 2)));
        checkOutput("t1_ir", 64'(if_ir), 64'(word(12'(4 * (i - 2)))));
      end
      if (i == 3) checkOutput("t1_se16_neg", 64'(if_se16), 64'hFFFF_8004);
      if (i == 4) checkOutput("t1_se16_pos", 64'(if_se16), 64'h0000_0008);
      step();
    end

    // Redirects while streaming (rvalid and pop coincide with the redirect)
    applyStimulus("t4_br_back", 2'b10, 32'h20, 32'h0000_FFFE, 32'h0, 32'h1C);
    applyStimulus("t4_br_fwd", 2'b10, 32'h20, 32'h0000_0003, 32'h0, 32'h30);
    checkOutput("t5_pre_valid", 64'(if_valid), 64'd1);
    applyStimulus("t5_reg", 2'b00, 32'h44, 32'hDEAD_BEEF, 32'h40, 32'h40);
    applyStimulus("t3_jump_hi", 2'b01, 32'h3000_0100, 32'h0800_0040, 32'h0, 32'h3000_0100);
    applyStimulus("t4_rsvd", 2'b11, 32'h500, 32'h0800_0040, 32'h200, 32'h200);

    // Back-to-back redirects: the second target wins
    redirect_valid = 1'b1;
    redirect_sel = 2'b00;
    redirect_target = 32'h300;
    #1;
    step();
    redirect_target = 32'h400;
    #1;
    checkOutput("b2b_req_blocked", 64'(im_req), 64'd0);
    checkOutput("b2b_flushed", 64'(if_valid), 64'd0);
    step();
    redirect_valid = 1'b0;
    #1;
    checkOutput("b2b_addr", 64'(im_addr), 64'h400);
    waitValid("b2b", 32'h400);

    // Credit limit with decode stalled
    if_ready = 1'b0;
    doReset();
    grants = 0;
    for (int i = 0; i < 10; i++) begin
      if (im_req && im_gnt) grants++;
      step();
    end
    checkOutput("t2_grants", 64'(grants), 64'd4);
    checkOutput("t2_req_stalled", 64'(im_req), 64'd0);
    checkOutput("t2_head_pc", 64'(if_pc), 64'h0);
    if_ready = 1'b1;
    #1;
    checkOutput("t2_pop_valid", 64'(if_valid), 64'd1);
    step();
    if_ready = 1'b0;
    #1;
    grants = 0;
    for (int i = 0; i < 8; i++) begin
      if (im_req && im_gnt) grants++;
      step();
    end
    checkOutput("t2_regrant", 64'(grants), 64'd1);
    checkOutput("t2_head_after", 64'(if_pc), 64'h4);

    // Jump with two responses outstanding
    if_ready = 1'b1;
    im_gnt = 1'b1;
    mem_go = 1'b0;
    doReset();
    step();
    step();
    im_gnt = 1'b0;
    applyStimulus("t3_jump", 2'b01, 32'h100, 32'h0800_0040, 32'h0, 32'h100);
    step();
    checkOutput("t3_next_pc", 64'(if_pc), 64'h104);
    checkOutput("t3_next_ir", 64'(if_ir), 64'(word(12'h104)));

    // Reset mid-burst with three requests in flight
    if_ready = 1'b1;
    im_gnt = 1'b1;
    mem_go = 1'b1;
    doReset();
    step();
    mem_go = 1'b0;
    step();
    step();
    step();
    checkOutput("t6_req_pre", 64'(im_req), 64'd1);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("t6_req_clr", 64'(im_req), 64'd0);
    checkOutput("t6_valid_clr", 64'(if_valid), 64'd0);
    mem_go = 1'b1;
    doReset();
    checkOutput("t6_restart_addr", 64'(im_addr), 64'h0);
    waitValid("t6_restart", 32'h0);
    step();
    checkOutput("t6_second_pc", 64'(if_pc), 64'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
